// File: rtl/core_branch_bp_pkg.sv
// core_branch_bp_pkg: condition encodings and predictor counter helpers shared by the branch unit
package core_branch_bp_pkg;
  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_EQ     = 3'd1,
    COND_NE     = 3'd2,
    COND_LT     = 3'd3,
    COND_GE     = 3'd4,
    COND_LTU    = 3'd5,
    COND_GEU    = 3'd6
  } cond_e;
  localparam logic [1:0] BHT_INIT = 2'b01;
  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic up);
    return up ? (c == 2'b11 ? c : c + 2'b01) : (c == 2'b00 ? c : c - 2'b01);
  endfunction
endpackage

// File: rtl/core_branch_bp_bht.sv
// core_bht: table of 2-bit saturating counters with a combinational lookup and a registered update
module core_bht
  import core_branch_bp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PC_W  = 31
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PC_W-1:0]          lookup_pc,
  output logic                     lookup_taken,
  input  logic                     upd_en,
  input  logic [$clog2(DEPTH)-1:0] upd_idx,
  input  logic                     upd_taken
);
  localparam int IDX_W = $clog2(DEPTH);
  logic [1:0] cnt_q [DEPTH];
  logic [1:0] cnt_d [DEPTH];
  logic unused_pc;
  assign unused_pc = ^lookup_pc[PC_W-1:IDX_W];
  always_comb begin
    cnt_d = cnt_q;
    if (upd_en) cnt_d[upd_idx] = sat_update(cnt_q[upd_idx], upd_taken);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '{default: BHT_INIT};
    else cnt_q <= cnt_d;
  end
  // lookup sees the pre-update value when it collides with an update
  assign lookup_taken = cnt_q[lookup_pc[IDX_W-1:0]][1];
endmodule

// File: rtl/core_branch_bp_raw_mask.sv
// core_raw_mask: OR of two optional one-hot register masks
module core_raw_mask #(
  parameter int NREGS = 16
) (
  input  logic                     a_en,
  input  logic [$clog2(NREGS)-1:0] a_rd,
  input  logic                     b_en,
  input  logic [$clog2(NREGS)-1:0] b_rd,
  output logic [NREGS-1:0]         mask
);
  assign mask = (a_en ? NREGS'(1) << a_rd : '0) | (b_en ? NREGS'(1) << b_rd : '0);
endmodule

// File: rtl/core_branch_bp.sv
// core_branch_bp: branch resolution with a 2-bit counter predictor, link writeback and RAW masks
module core_branch_bp
  import core_branch_bp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PC_W      = XLEN - 1,
  parameter int OFS_W     = 12,
  parameter int BHT_DEPTH = 16,
  parameter int INSN_HW   = 2,
  parameter int NREGS     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     wb_stall,
  input  logic [PC_W-1:0]          dec_pc,
  input  logic [OFS_W-1:0]         dec_offset,
  input  logic                     dec_indirect,
  input  logic [2:0]               dec_cond,
  input  logic [$clog2(NREGS)-1:0] dec_rd,
  input  logic                     dec_writeback,
  input  logic                     pred_taken,
  input  logic [XLEN-1:0]          a,
  input  logic [XLEN-1:0]          b,
  input  logic [PC_W-1:0]          lookup_pc,
  output logic                     lookup_taken,
  output logic                     wb_ready,
  output logic [$clog2(NREGS)-1:0] wb_rd,
  output logic [XLEN-1:0]          wb_value,
  output logic [NREGS-1:0]         raw_mask,
  output logic [PC_W-1:0]          target,
  output logic                     redirect,
  output logic                     stall
);
  localparam int RD_W  = $clog2(NREGS);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] value;
  } wb_line_t;
  cond_e           cond;
  logic [XLEN:0]   diff;
  logic            eq, lt, ltu, taken, accept;
  logic [PC_W-1:0] fall_through, taken_tgt;
  logic            redirect_q, redirect_d;
  logic [PC_W-1:0] target_q, target_d;
  logic            upd_en_q, upd_en_d, upd_taken_q, upd_taken_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
  wb_line_t        hold_q, hold_d, wb_q, wb_d;
  always_comb begin
    cond = cond_e'(dec_cond);
    diff = {1'b0, a} - {1'b0, b};
    eq = a == b;
    ltu = diff[XLEN];
    lt = diff[XLEN-1] ^ ((a[XLEN-1] ^ b[XLEN-1]) & (a[XLEN-1] ^ diff[XLEN-1]));
    taken = cond == COND_ALWAYS ? 1'b1 :
            cond == COND_EQ     ? eq :
            cond == COND_NE     ? !eq :
            cond == COND_LT     ? lt :
            cond == COND_GE     ? !lt :
            cond == COND_LTU    ? ltu :
            cond == COND_GEU    ? !ltu : 1'b0;
    fall_through = dec_pc + PC_W'(INSN_HW);
    taken_tgt = dec_indirect ? PC_W'(a[XLEN-1:1])
                             : dec_pc + {{(PC_W-OFS_W){dec_offset[OFS_W-1]}}, dec_offset};
    // a branch arriving while a redirect is out is on the flushed path
    accept = start && !redirect_q;
    redirect_d = accept && (taken != pred_taken || dec_indirect);
    target_d = redirect_d ? (taken ? taken_tgt : fall_through) : target_q;
    upd_en_d = accept;
    upd_idx_d = dec_pc[IDX_W-1:0];
    upd_taken_d = taken;
    hold_d = hold_q;
    wb_d = wb_q;
    if (!wb_stall) begin
      hold_d.valid = accept && dec_writeback;
      hold_d.rd = dec_rd;
      hold_d.value = XLEN'({fall_through, 1'b0});
      wb_d = hold_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_q <= 1'b1;
      target_q <= '0;
      upd_en_q <= 1'b0;
      upd_idx_q <= '0;
      upd_taken_q <= 1'b0;
      hold_q <= '0;
      wb_q <= '0;
    end else begin
      redirect_q <= redirect_d;
      target_q <= target_d;
      upd_en_q <= upd_en_d;
      upd_idx_q <= upd_idx_d;
      upd_taken_q <= upd_taken_d;
      hold_q <= hold_d;
      wb_q <= wb_d;
    end
  end
  core_bht #(.DEPTH(BHT_DEPTH), .PC_W(PC_W)) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_pc   (lookup_pc),
    .lookup_taken(lookup_taken),
    .upd_en      (upd_en_q),
    .upd_idx     (upd_idx_q),
    .upd_taken   (upd_taken_q)
  );
  core_raw_mask #(.NREGS(NREGS)) u_raw (
    .a_en(start && dec_writeback),
    .a_rd(dec_rd),
    .b_en(hold_q.valid),
    .b_rd(hold_q.rd),
    .mask(raw_mask)
  );
  assign redirect = redirect_q;
  assign target = target_q;
  assign stall = start || redirect_q;
  assign wb_ready = wb_q.valid;
  assign wb_rd = wb_q.rd;
  assign wb_value = wb_q.value;
endmodule

// File: tb/tb_core_branch_bp.sv
// tb_core_branch_bp: directed vectors with a cycle-stamped scoreboard checked by a negedge monitor
module tb_core_branch_bp;
  import core_branch_bp_pkg::*;
  typedef struct {
    int          cyc;
    logic [31:0] v;
    logic [3:0]  rd;
  } ev_t;
  logic        clk = 0, rst_n = 0, start = 0, wb_stall = 0;
  logic        dec_indirect = 0, dec_writeback = 0, pred_taken = 0;
  logic [30:0] dec_pc = '0, lookup_pc = '0;
  logic [11:0] dec_offset = '0;
  logic [2:0]  dec_cond = '0;
  logic [3:0]  dec_rd = '0;
  logic [31:0] a = '0, b = '0;
  logic        lookup_taken, wb_ready, redirect, stall;
  logic [3:0]  wb_rd;
  logic [31:0] wb_value;
  logic [15:0] raw_mask;
  logic [30:0] target;
  int          cyc = 0, n_chk = 0, n_fail = 0;
  ev_t         redir_q[$], wb_q[$], look_q[$], raw_q[$];
  logic        mon_e, mon_p;

  core_branch_bp dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wb_stall(wb_stall),
    .dec_pc(dec_pc), .dec_offset(dec_offset), .dec_indirect(dec_indirect),
    .dec_cond(dec_cond), .dec_rd(dec_rd), .dec_writeback(dec_writeback),
    .pred_taken(pred_taken), .a(a), .b(b), .lookup_pc(lookup_pc),
    .lookup_taken(lookup_taken), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_value(wb_value), .raw_mask(raw_mask), .target(target),
    .redirect(redirect), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t ev(input int c, input logic [31:0] v, input logic [3:0] r);
    ev_t e;
    e.cyc = c;
    e.v = v;
    e.rd = r;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_e = redir_q.size() > 0 && redir_q[0].cyc == cyc;
      if (mon_e || redirect) begin
        check("redirect", 32'(redirect), 32'(mon_e));
        if (mon_e && redirect) begin
          check("target", 32'(target), redir_q[0].v);
          check("stall", 32'(stall), 32'd1);
        end
      end
      if (mon_e) redir_q.delete(0);
      mon_e = wb_q.size() > 0 && wb_q[0].cyc == cyc;
      mon_p = wb_ready && !wb_stall;
      if (mon_e || mon_p) begin
        check("wb_ready", 32'(mon_p), 32'(mon_e));
        if (mon_e && mon_p) begin
          check("wb_rd", 32'(wb_rd), 32'(wb_q[0].rd));
          check("wb_value", wb_value, wb_q[0].v);
        end
      end
      if (mon_e) wb_q.delete(0);
      if (look_q.size() > 0 && look_q[0].cyc == cyc) begin
        check("lookup_taken", 32'(lookup_taken), look_q[0].v);
        look_q.delete(0);
      end
      if (raw_q.size() > 0 && raw_q[0].cyc == cyc) begin
        check("raw_mask", 32'(raw_mask), raw_q[0].v);
        raw_q.delete(0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [2:0] cond, input logic [30:0] pc, input logic [11:0] off,
                    input logic ind, input logic pt, input logic [31:0] av, input logic [31:0] bv,
                    input logic wr, input logic [3:0] rd, input logic er, input logic [30:0] et);
    dec_cond = cond;
    dec_pc = pc;
    dec_offset = off;
    dec_indirect = ind;
    pred_taken = pt;
    a = av;
    b = bv;
    dec_writeback = wr;
    dec_rd = rd;
    start = 1;
    if (er) redir_q.push_back(ev(cyc + 1, 32'(et), 4'd0));
    tick();
    start = 0;
    dec_writeback = 0;
    dec_indirect = 0;
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1;
    redir_q.push_back(ev(cyc, 32'h0, 4'd0));
    raw_q.push_back(ev(cyc, 32'h0, 4'd0));
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 31'(i);
      look_q.push_back(ev(cyc, 32'd0, 4'd0));
      tick();
    end
    // BEQ taken against a not-taken prediction
    br(COND_EQ, 31'h100, 12'd8, 0, 0, 32'd5, 32'd5, 0, 4'd0, 1, 31'h108);
    lookup_pc = 31'h100;
    look_q.push_back(ev(cyc, 32'd0, 4'd0));
    tick();
    look_q.push_back(ev(cyc, 32'd1, 4'd0));
    tick();
    // signed vs unsigned less-than, then a branch dropped under the redirect
    br(COND_LT, 31'h200, 12'd4, 0, 1, 32'h8000_0000, 32'd1, 0, 4'd0, 0, 31'h0);
    br(COND_LTU, 31'h200, 12'd4, 0, 1, 32'h8000_0000, 32'd1, 0, 4'd0, 1, 31'h202);
    br(COND_NE, 31'h300, 12'd2, 0, 1, 32'd7, 32'd7, 1, 4'd3, 0, 31'h0);
    lookup_pc = 31'h0;
    raw_q.push_back(ev(cyc, 32'h0, 4'd0));
    tick();
    look_q.push_back(ev(cyc, 32'd1, 4'd0));
    tick();
    br(COND_LT, 31'h210, 12'd4, 0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 0, 4'd0, 1, 31'h212);
    tick();
    br(COND_GE, 31'h220, 12'd4, 0, 1, 32'hFFFF_FFFF, 32'd1, 0, 4'd0, 1, 31'h222);
    tick();
    br(COND_GEU, 31'h230, 12'hFFC, 0, 0, 32'hFFFF_FFFF, 32'd1, 0, 4'd0, 1, 31'h22C);
    tick();
    br(3'd7, 31'h240, 12'd8, 0, 1, 32'd0, 32'd0, 0, 4'd0, 1, 31'h242);
    tick();
    // indirect call with link writeback
    raw_q.push_back(ev(cyc, 32'h4000, 4'd0));
    br(COND_ALWAYS, 31'h40, 12'd0, 1, 1, 32'h2001, 32'd0, 1, 4'd14, 1, 31'h1000);
    raw_q.push_back(ev(cyc, 32'h4000, 4'd0));
    wb_q.push_back(ev(cyc + 1, 32'h84, 4'd14));
    tick();
    raw_q.push_back(ev(cyc, 32'h0, 4'd0));
    tick();
    tick();
    // same call with the writeback port busy for three cycles
    br(COND_ALWAYS, 31'h40, 12'd0, 1, 1, 32'h2001, 32'd0, 1, 4'd14, 1, 31'h1000);
    wb_stall = 1;
    for (int i = 0; i < 3; i++) begin
      raw_q.push_back(ev(cyc, 32'h4000, 4'd0));
      tick();
    end
    wb_stall = 0;
    wb_q.push_back(ev(cyc + 1, 32'h84, 4'd14));
    tick();
    tick();
    tick();
    // counter saturation at index 3
    for (int i = 0; i < 4; i++)
      br(COND_ALWAYS, 31'h13, 12'd4, 0, 1, 32'd0, 32'd0, 0, 4'd0, 0, 31'h0);
    br(COND_NE, 31'h23, 12'd4, 0, 0, 32'd9, 32'd9, 0, 4'd0, 0, 31'h0);
    lookup_pc = 31'h3;
    look_q.push_back(ev(cyc, 32'd1, 4'd0));
    tick();
    look_q.push_back(ev(cyc, 32'd1, 4'd0));
    br(COND_NE, 31'h3, 12'd4, 0, 0, 32'd9, 32'd9, 0, 4'd0, 0, 31'h0);
    look_q.push_back(ev(cyc, 32'd1, 4'd0));
    tick();
    look_q.push_back(ev(cyc, 32'd0, 4'd0));
    tick();
    // target wraps modulo 2^PC_W
    br(COND_ALWAYS, 31'h7FFF_FFFF, 12'd1, 0, 0, 32'd0, 32'd0, 0, 4'd0, 1, 31'h0);
    tick();
    // reset while a redirect and a link are in flight
    br(COND_ALWAYS, 31'h500, 12'h010, 0, 0, 32'd0, 32'd0, 1, 4'd5, 0, 31'h0);
    rst_n = 0;
    tick();
    rst_n = 1;
    redir_q.push_back(ev(cyc, 32'h0, 4'd0));
    tick();
    tick();
    tick();
    check("queues_drained", 32'(redir_q.size() + wb_q.size() + look_q.size() + raw_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
